ascii2bin_stream: RTL and testbench
===================================

Name: ascii2bin_stream

Overview:
- Streaming ASCII-hex to binary parser, converting in the opposite direction to the team's binary-to-ASCII hex formatter.
- Accepts one ASCII character per valid/ready handshake, typically from the UART receive path.
- Accumulates hex digits MSB-first into a right-aligned binary word.
- Presents the completed word on a valid/ready output when a terminator arrives or the digit limit is reached.

Parameters:
- NDIGITS, 8, maximum hex digits per token; output width is 4*NDIGITS.
- CNTW, 4, width of the digit count; must satisfy 2**CNTW > NDIGITS.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- in_data  input  8  ASCII character.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts a character this cycle.
- out_data  output  4*NDIGITS  parsed value, right-aligned, zero-extended.
- out_count  output  CNTW  number of digits in the token (1..NDIGITS).
- out_valid  output  1  out_data/out_count are valid.
- out_ready  input  1  consumer accepts the output.
- err  output  1  one-cycle pulse: an illegal character discarded the token.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=ACCUM, acc=0, count=0, out_valid=0, err=0.
- in_ready = (state==ACCUM) && !rst, so it is 0 during the reset cycle.
- Character accept: a character is accepted on a rising clk edge with in_valid && in_ready. Unaccepted in_data is ignored.
- Character classes:
  - digit: 0x30-0x39, nibble = c-0x30.
  - hex upper: 0x41-0x46, nibble = c-0x37.
  - terminator: 0x0D or 0x0A.
  - everything else is illegal.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- ACCUM, hex char accepted:
  - acc <= {acc[4*NDIGITS-5:0], nibble}; count <= count+1.
  - If count+1 == NDIGITS, go to DONE on the same edge (auto-terminate).
- ACCUM, terminator accepted:
  - count==0: ignore, stay in ACCUM. This lets CRLF and blank lines pass without producing output.
  - count>0: go to DONE.
- ACCUM, illegal char accepted:
  - acc<=0, count<=0, err<=1 for exactly the next cycle; stay in ACCUM.
  - No output is produced for the discarded token.
- DONE:
  - out_data=acc, out_count=count, both held stable while out_valid=1 && !out_ready.
  - When out_ready is high: acc<=0, count<=0, go to ACCUM. in_ready returns the following cycle.
- Latency: the edge that accepts the final digit or terminator makes out_valid high in the next cycle. Minimum throughput is one token per (digits+1 terminator+1) cycles.
- Terminator after auto-terminate: the terminator is consumed in ACCUM with count==0 and ignored.
- Reset mid-token or in DONE: the partial or pending token is lost, out_valid drops, err clears.
- err is registered and never asserts in the same cycle as out_valid from the same character.

Optional Feature:
- Macro: ASCII2BIN_LOWERCASE_EN.
- Defined: 0x61-0x66 ('a'-'f') are hex chars, nibble = c-0x57.
- Undefined: 'a'-'f' are illegal and trigger err plus token discard.

Test Plan:
- Reset, then send "1A3F",0x0D with out_ready=1 -> out_valid one cycle after 0x0D accepted; out_data=0x00001A3F, out_count=4; err never set.
- Send "DEADBEEF" with no terminator, out_ready=0 for 5 cycles -> out_valid one cycle after 'F'; in_ready=0 and out_data=0xDEADBEEF held 5 cycles. Then send 0x0D -> no second output.
- Send 0x0D,0x0A,0x0A,"7",0x0A -> exactly one output: out_data=0x00000007, out_count=1.
- Send "12G4",0x0D -> err pulse one cycle after 'G'; then '4',0x0D yield out_data=0x00000004, out_count=1.
- Send "ab",0x0D -> with ASCII2BIN_LOWERCASE_EN: out_data=0x000000AB. Without it: err after 'a', err again after 'b', no output.
- Send "12" then assert rst one cycle, then "5",0x0D -> out_data=0x00000005, out_count=1; in_ready=0 during rst.

Source files
------------

// File: rtl/ascii2bin_stream.sv
// Streaming ASCII-hex to binary parser: hex digits in, right-aligned word out on terminator or digit limit.
// Optional build macro ASCII2BIN_LOWERCASE_EN also accepts 'a'-'f' as hex digits.
module ascii2bin_stream #(
   parameter int NDIGITS = 8,
   parameter int CNTW    = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [4*NDIGITS-1:0]   out_data,
   output logic [CNTW-1:0]        out_count,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   err
);

   localparam int DW = 4 * NDIGITS;
   localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NDIGITS);

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      CLS_HEX     = 2'd0,
      CLS_TERM    = 2'd1,
      CLS_ILLEGAL = 2'd2
   } char_class_t;

   state_t          state_q;
   logic [DW-1:0]   acc_q;
   logic [CNTW-1:0] count_q;
   logic            out_valid_q;
   logic            err_q;

   char_class_t     char_class;
   logic [3:0]      char_nibble;
   logic [DW-1:0]   acc_d;
   logic [CNTW-1:0] count_d;
   logic            accept;

   // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      char_class  = CLS_ILLEGAL;
      char_nibble = 4'h0;
      if (in_data >= 8'h30 && in_data <= 8'h39) begin
         char_class  = CLS_HEX;
         char_nibble = in_data[3:0];
      end else if (in_data >= 8'h41 && in_data <= 8'h46) begin
         char_class  = CLS_HEX;
         char_nibble = in_data[3:0] + 4'd9;
`ifdef ASCII2BIN_LOWERCASE_EN
      end else if (in_data >= 8'h61 && in_data <= 8'h66) begin
         char_class  = CLS_HEX;
         char_nibble = in_data[3:0] + 4'd9;
`endif
      end else if (in_data == 8'h0D || in_data == 8'h0A) begin
         char_class  = CLS_TERM;
      end
   end

   // Shift left rather than slice so NDIGITS=1 still elaborates.
   assign acc_d   = (acc_q << 4) | DW'(char_nibble);
   assign count_d = count_q + CNT_ONE;

   assign in_ready  = (state_q == ACCUM) && !rst;
   assign accept    = in_valid && in_ready;
   assign out_data  = acc_q;
   assign out_count = count_q;
   assign out_valid = out_valid_q;
   assign err       = err_q;

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ACCUM;
         acc_q       <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            ACCUM: begin
               if (accept) begin
                  case (char_class)
                     CLS_HEX: begin
                        acc_q   <= acc_d;
                        count_q <= count_d;
                        if (count_d == CNT_LAST) begin
                           state_q     <= DONE;
                           out_valid_q <= 1'b1;
                        end
                     end
                     CLS_TERM: begin
                        // Empty tokens (CR after LF, blank lines) produce nothing.
                        if (count_q != '0) begin
                           state_q     <= DONE;
                           out_valid_q <= 1'b1;
                        end
                     end
                     default: begin
                        acc_q   <= '0;
                        count_q <= '0;
                        err_q   <= 1'b1;
                     end
                  endcase
               end
            end
            DONE: begin
               if (out_ready) begin
                  acc_q       <= '0;
                  count_q     <= '0;
                  state_q     <= ACCUM;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= ACCUM;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ascii2bin_stream.sv
// Directed testbench for ascii2bin_stream with default parameters.
module tb_ascii2bin_stream;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] out_data;
   logic [3:0]  out_count;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        err;

   int tests_run = 0;
   int tests_failed = 0;

   logic [31:0] got_data[$];
   logic [3:0]  got_cnt[$];
   int          err_pulses = 0;
   int          overlap = 0;

   ascii2bin_stream #(.NDIGITS(8), .CNTW(4)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_count(out_count), .out_valid(out_valid),
      .out_ready(out_ready), .err(err)
   );

   always #5 clk = ~clk;

   // Inputs change 1 time unit after posedge; negedge sampling sees them settled.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         got_data.push_back(out_data);
         got_cnt.push_back(out_count);
      end
      if (err) err_pulses++;
      if (err && out_valid) overlap++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_char(input logic [7:0] c);
      bit ok = 1'b0;
      in_data  = c;
      in_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
         tick();
      end
      in_valid = 1'b0;
      tests_run++;
      if (!ok) begin
         $display("FAIL accept_timeout: char %h not accepted, got in_ready=0 expected 1", c);
         tests_failed++;
      end
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_char(s[i]);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0) begin
         $display("FAIL reset_outputs: got rdy=%b vld=%b err=%b expected 0 0 0", in_ready, out_valid, err);
         tests_failed++;
      end
      tick();
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b1 || out_data !== 32'h0 || out_count !== 4'h0) begin
         $display("FAIL reset_release: got rdy=%b data=%h cnt=%0d expected 1 0 0", in_ready, out_data, out_count);
         tests_failed++;
      end
      tick();
   endtask

   task automatic test_basic_token();
      int n0 = got_data.size();
      int e0 = err_pulses;
      out_ready = 1'b1;
      send_str("1A3F");
      tests_run++;
      if (out_valid !== 1'b0) begin
         $display("FAIL basic_early_valid: got out_valid=%b expected 0", out_valid);
         tests_failed++;
      end
      send_char(8'h0D);
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 32'h00001A3F || out_count !== 4'd4) begin
         $display("FAIL basic_token: got vld=%b data=%h cnt=%0d expected 1 00001a3f 4", out_valid, out_data, out_count);
         tests_failed++;
      end
      tick(); tick();
      tests_run++;
      if (got_data.size() != n0 + 1 || err_pulses != e0) begin
         $display("FAIL basic_handshake: got outputs=%0d errs=%0d expected 1 0", got_data.size() - n0, err_pulses - e0);
         tests_failed++;
      end
   endtask

   task automatic test_auto_terminate();
      int n0;
      out_ready = 1'b0;
      send_str("DEADBEEF");
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_count !== 4'd8 || in_ready !== 1'b0) begin
         $display("FAIL auto_term: got vld=%b data=%h cnt=%0d rdy=%b expected 1 deadbeef 8 0", out_valid, out_data, out_count, in_ready);
         tests_failed++;
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests_run++;
         if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || in_ready !== 1'b0) begin
            $display("FAIL auto_hold[%0d]: got vld=%b data=%h rdy=%b expected 1 deadbeef 0", i, out_valid, out_data, in_ready);
            tests_failed++;
         end
         tick();
      end
      n0 = got_data.size();
      out_ready = 1'b1;
      tick();
      tests_run++;
      if (got_data.size() != n0 + 1 || in_ready !== 1'b1) begin
         $display("FAIL auto_release: got outputs=%0d rdy=%b expected 1 1", got_data.size() - n0, in_ready);
         tests_failed++;
      end
      send_char(8'h0D);
      tick(); tick(); tick();
      tests_run++;
      if (got_data.size() != n0 + 1 || out_valid !== 1'b0) begin
         $display("FAIL auto_trailing_cr: got outputs=%0d vld=%b expected 1 0", got_data.size() - n0, out_valid);
         tests_failed++;
      end
   endtask

   task automatic test_blank_lines();
      int n0 = got_data.size();
      out_ready = 1'b1;
      send_char(8'h0D); send_char(8'h0A); send_char(8'h0A);
      send_char(8'h37); send_char(8'h0A);
      tick(); tick();
      tests_run++;
      if (got_data.size() != n0 + 1) begin
         $display("FAIL blank_count: got outputs=%0d expected 1", got_data.size() - n0);
         tests_failed++;
      end else if (got_data[n0] !== 32'h7 || got_cnt[n0] !== 4'd1) begin
         tests_failed++;
         $display("FAIL blank_value: got data=%h cnt=%0d expected 00000007 1", got_data[n0], got_cnt[n0]);
      end
   endtask

   task automatic test_illegal();
      int n0 = got_data.size();
      int e0 = err_pulses;
      out_ready = 1'b1;
      send_str("12");
      tests_run++;
      if (err !== 1'b0) begin
         $display("FAIL illegal_pre: got err=%b expected 0", err);
         tests_failed++;
      end
      send_char(8'h47);
      tests_run++;
      if (err !== 1'b1 || out_count !== 4'd0) begin
         $display("FAIL illegal_pulse: got err=%b cnt=%0d expected 1 0", err, out_count);
         tests_failed++;
      end
      tick();
      tests_run++;
      if (err !== 1'b0) begin
         $display("FAIL illegal_width: got err=%b expected 0", err);
         tests_failed++;
      end
      send_char(8'h34); send_char(8'h0D);
      tick(); tick();
      tests_run++;
      if (got_data.size() != n0 + 1 || err_pulses != e0 + 1) begin
         $display("FAIL illegal_count: got outputs=%0d errs=%0d expected 1 1", got_data.size() - n0, err_pulses - e0);
         tests_failed++;
      end else if (got_data[n0] !== 32'h4 || got_cnt[n0] !== 4'd1) begin
         tests_failed++;
         $display("FAIL illegal_value: got data=%h cnt=%0d expected 00000004 1", got_data[n0], got_cnt[n0]);
      end
   endtask

   task automatic test_lowercase();
      int n0 = got_data.size();
      int e0 = err_pulses;
      out_ready = 1'b1;
      send_char(8'h61);
`ifdef ASCII2BIN_LOWERCASE_EN
      send_char(8'h62); send_char(8'h0D);
      tick(); tick();
      tests_run++;
      if (got_data.size() != n0 + 1 || err_pulses != e0) begin
         $display("FAIL lower_count: got outputs=%0d errs=%0d expected 1 0", got_data.size() - n0, err_pulses - e0);
         tests_failed++;
      end else if (got_data[n0] !== 32'hAB || got_cnt[n0] !== 4'd2) begin
         tests_failed++;
         $display("FAIL lower_value: got data=%h cnt=%0d expected 000000ab 2", got_data[n0], got_cnt[n0]);
      end
`else
      tests_run++;
      if (err !== 1'b1) begin
         $display("FAIL lower_err_a: got err=%b expected 1", err);
         tests_failed++;
      end
      send_char(8'h62);
      tests_run++;
      if (err !== 1'b1) begin
         $display("FAIL lower_err_b: got err=%b expected 1", err);
         tests_failed++;
      end
      send_char(8'h0D);
      tick(); tick();
      tests_run++;
      if (got_data.size() != n0 || err_pulses != e0 + 2) begin
         $display("FAIL lower_discard: got outputs=%0d errs=%0d expected 0 2", got_data.size() - n0, err_pulses - e0);
         tests_failed++;
      end
`endif
   endtask

   task automatic test_reset_mid_token();
      int n0 = got_data.size();
      out_ready = 1'b1;
      send_str("12");
      rst = 1'b1;
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b0) begin
         $display("FAIL midrst_ready: got in_ready=%b expected 0", in_ready);
         tests_failed++;
      end
      tick();
      rst = 1'b0;
      tests_run++;
      if (out_count !== 4'd0 || out_data !== 32'h0 || out_valid !== 1'b0) begin
         $display("FAIL midrst_clear: got cnt=%0d data=%h vld=%b expected 0 0 0", out_count, out_data, out_valid);
         tests_failed++;
      end
      send_char(8'h35); send_char(8'h0D);
      tick(); tick();
      tests_run++;
      if (got_data.size() != n0 + 1) begin
         $display("FAIL midrst_count: got outputs=%0d expected 1", got_data.size() - n0);
         tests_failed++;
      end else if (got_data[n0] !== 32'h5 || got_cnt[n0] !== 4'd1) begin
         tests_failed++;
         $display("FAIL midrst_value: got data=%h cnt=%0d expected 00000005 1", got_data[n0], got_cnt[n0]);
      end
   endtask

   initial begin
      test_reset();
      test_basic_token();
      test_auto_terminate();
      test_blank_lines();
      test_illegal();
      test_lowercase();
      test_reset_mid_token();
      tests_run++;
      if (overlap != 0) begin
         $display("FAIL err_valid_overlap: got %0d cycles expected 0", overlap);
         tests_failed++;
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
